q_row_fetch: RTL and testbench

Gathers one Q-table row, i.e. the ACTIONS Q-values of a single state, into the packed bus consumed by the max-reduction pipeline. On a request it issues ACTIONS sequential reads to the Q-table RAM, one per cycle, and assembles the returned words in action order. It then presents the row with a one-cycle valid pulse. It sits between the agent control FSM (next-state request) and max_top's i_data/i_valid input.

---
 rtl/q_row_fetch_pkg.sv | 27 ++
 rtl/q_row_fetch_assembler.sv | 60 ++++++
 rtl/q_row_fetch.sv | 130 +++++++++++++
 tb/tb_q_row_fetch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/q_row_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : q_row_fetch_pkg                                                 |
// | Purpose  : Shared widths and FSM encoding for the Q-row fetch path, so the |
// |            fetcher and the max-reduction pipeline agree on bus packing.    |
// | Contents : DATA_WIDTH, ACTIONS, ACTIONS_WIDTH, STATE_WIDTH, ADDR_WIDTH,    |
// |            ROW_WIDTH, fetch_state_e.                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package q_row_fetch_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ACTIONS       = 4;                       // power of two, >= 2
  localparam int ACTIONS_WIDTH = $clog2(ACTIONS);
  localparam int STATE_WIDTH   = 4;
  localparam int ADDR_WIDTH    = STATE_WIDTH + ACTIONS_WIDTH;
  localparam int ROW_WIDTH     = DATA_WIDTH * ACTIONS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

endpackage : q_row_fetch_pkg
`default_nettype wire

// File: rtl/q_row_fetch_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : q_row_fetch_assembler                                           |
// | Purpose  : Row register that collects returned RAM words into their action |
// |            slot, plus a published copy that only changes when a complete   |
// |            row is handed over.                                             |
// | Ports    : clk, rst        clock / async active-high reset                 |
// |            clear_i         zero the working row (start of a new fetch)     |
// |            wr_en_i         write wr_data_i into slot wr_idx_i              |
// |            wr_idx_i        action slot index                               |
// |            wr_data_i       RAM word                                        |
// |            publish_i       copy working row (incl. this cycle's write) out |
// |            row_o           published row, action a at [DATA_WIDTH*a +: ..] |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module q_row_fetch_assembler
  import q_row_fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic [ACTIONS_WIDTH-1:0] wr_idx_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     publish_i,
  output logic [ROW_WIDTH-1:0]     row_o
);

  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [ROW_WIDTH-1:0] out_q;

  always_comb begin
    row_d = row_q;
    if (wr_en_i) begin
      row_d[DATA_WIDTH*wr_idx_i +: DATA_WIDTH] = wr_data_i;
    end
  end

  // The publish copy takes row_d so the last word, landing in the same cycle,
  // is part of the handed-over row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      out_q <= '0;
    end else begin
      if (clear_i) begin
        row_q <= '0;
      end else begin
        row_q <= row_d;
      end
      if (publish_i) begin
        out_q <= row_d;
      end
    end
  end

  assign row_o = out_q;

endmodule : q_row_fetch_assembler
`default_nettype wire

// File: rtl/q_row_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : q_row_fetch                                                     |
// | Purpose  : On request, reads the ACTIONS Q-values of one state from the    |
// |            Q-table RAM (one read per cycle, ascending action order) and    |
// |            presents the packed row with a one-cycle valid pulse.           |
// | Ports    : clk, rst        clock / async active-high reset                 |
// |            i_valid,i_state request and state index (taken when o_ready)    |
// |            o_ready         high only while idle                            |
// |            o_ram_rd_en     RAM read strobe                                 |
// |            o_ram_addr      {state, action}                                 |
// |            i_ram_data      RAM data, one cycle after the strobe            |
// |            o_data,o_state  assembled row and its state, held until next    |
// |            o_valid         one-cycle pulse when o_data/o_state complete    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module q_row_fetch
  import q_row_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [STATE_WIDTH-1:0] i_state,
  output logic                   o_ready,
  output logic                   o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0]  o_ram_addr,
  input  logic [DATA_WIDTH-1:0]  i_ram_data,
  output logic [ROW_WIDTH-1:0]   o_data,
  output logic [STATE_WIDTH-1:0] o_state,
  output logic                   o_valid
);

  fetch_state_e             state_q, state_d;
  logic [ACTIONS_WIDTH-1:0] cnt_q, cnt_d;
  logic [STATE_WIDTH-1:0]   req_state_q, req_state_d;
  logic [STATE_WIDTH-1:0]   out_state_q;
  logic                     rd_en_dly_q;
  logic [ACTIONS_WIDTH-1:0] idx_dly_q;

  logic w_accept;
  logic w_rd_en;
  logic w_publish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_state_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_state_q <= req_state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_state_d = req_state_q;
    o_ready     = 1'b0;
    w_accept    = 1'b0;
    w_rd_en     = 1'b0;
    w_publish   = 1'b0;
    o_valid     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_accept    = 1'b1;
          req_state_d = i_state;
          cnt_d       = '0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        w_rd_en = 1'b1;
        // Counter parks on the last action instead of wrapping.
        if (cnt_q == ACTIONS_WIDTH'(ACTIONS - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + ACTIONS_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        // Last word returns this cycle; publish it together with the row.
        w_publish = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        o_valid = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobe and slot index follow the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_dly_q <= 1'b0;
      idx_dly_q   <= '0;
      out_state_q <= '0;
    end else begin
      rd_en_dly_q <= w_rd_en;
      idx_dly_q   <= cnt_q;
      if (w_publish) begin
        out_state_q <= req_state_q;
      end
    end
  end

  q_row_fetch_assembler u_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_accept),
    .wr_en_i   (rd_en_dly_q),
    .wr_idx_i  (idx_dly_q),
    .wr_data_i (i_ram_data),
    .publish_i (w_publish),
    .row_o     (o_data)
  );

  assign o_ram_rd_en = w_rd_en;
  assign o_ram_addr  = w_rd_en ? {req_state_q, cnt_q} : '0;
  assign o_state     = out_state_q;

endmodule : q_row_fetch
`default_nettype wire

// File: tb/tb_q_row_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_q_row_fetch                                                  |
// | Purpose  : Directed self-checking bench for q_row_fetch (ACTIONS=4,        |
// |            DATA_WIDTH=32, STATE_WIDTH=4). RAM word(s,a) = 16*s + a + 1.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_q_row_fetch;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic [3:0]   i_state;
  logic         o_ready;
  logic         o_ram_rd_en;
  logic [5:0]   o_ram_addr;
  logic [31:0]  i_ram_data;
  logic [127:0] o_data;
  logic [3:0]   o_state;
  logic         o_valid;

  logic [31:0]  mem [0:63];
  int           n_cmp;
  int           n_err;

  q_row_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_state     (i_state),
    .o_ready     (o_ready),
    .o_ram_rd_en (o_ram_rd_en),
    .o_ram_addr  (o_ram_addr),
    .i_ram_data  (i_ram_data),
    .o_data      (o_data),
    .o_state     (o_state),
    .o_valid     (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (o_ram_rd_en) i_ram_data <= mem[o_ram_addr];
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns just after the accepting edge.
  task automatic request(input logic [3:0] s);
    i_valid = 1'b1;
    i_state = s;
    check_eq("ready_before_req", {127'd0, o_ready}, 128'd1);
    @(posedge clk);
  endtask

  // Full fetch with cycle-exact checks: reads in cycles 1..4, drain 5, valid 6.
  task automatic fetch_row(input logic [3:0] s, input logic [127:0] exp_row, input string tag);
    logic [5:0] exp_addr;
    request(s);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) i_valid = 1'b0;
      if (k <= 4) begin
        exp_addr = {s, 2'(k - 1)};
        check_eq({tag, "_rd_en"}, {127'd0, o_ram_rd_en}, 128'd1);
        check_eq({tag, "_addr"}, {122'd0, o_ram_addr}, {122'd0, exp_addr});
        check_eq({tag, "_busy"}, {127'd0, o_ready}, 128'd0);
      end else if (k == 5) begin
        check_eq({tag, "_drain_rd"}, {127'd0, o_ram_rd_en}, 128'd0);
        check_eq({tag, "_drain_valid"}, {127'd0, o_valid}, 128'd0);
      end else begin
        check_eq({tag, "_valid"}, {127'd0, o_valid}, 128'd1);
        check_eq({tag, "_data"}, o_data, exp_row);
        check_eq({tag, "_state"}, {124'd0, o_state}, {124'd0, s});
      end
    end
    @(negedge clk);
    check_eq({tag, "_pulse_end"}, {127'd0, o_valid}, 128'd0);
    check_eq({tag, "_idle_ready"}, {127'd0, o_ready}, 128'd1);
  endtask

  initial begin
    logic [127:0] held_data;
    logic [3:0]   held_state;
    logic         bad;
    logic [31:0]  mx;

    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_state    = 4'd0;
    i_ram_data = 32'd0;
    for (int s = 0; s < 16; s++)
      for (int a = 0; a < 4; a++)
        mem[s*4 + a] = 32'(16*s + a + 1);

    repeat (2) @(negedge clk);
    check_eq("rst_ready", {127'd0, o_ready}, 128'd1);
    check_eq("rst_rd_en", {127'd0, o_ram_rd_en}, 128'd0);
    check_eq("rst_addr",  {122'd0, o_ram_addr}, 128'd0);
    check_eq("rst_data",  o_data, 128'd0);
    check_eq("rst_state", {124'd0, o_state}, 128'd0);
    check_eq("rst_valid", {127'd0, o_valid}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch of state 3.
    fetch_row(4'd3, 128'h00000034_00000033_00000032_00000031, "s3");

    // Busy ignore: state 5 raised in cycle 2 and held; taken in cycle 7.
    request(4'd1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) i_valid = 1'b0;
      if (k == 2) begin i_valid = 1'b1; i_state = 4'd5; end
      if (k >= 2 && k <= 6) check_eq("busy_ready", {127'd0, o_ready}, 128'd0);
      if (k == 6) begin
        check_eq("busy_s1_valid", {127'd0, o_valid}, 128'd1);
        check_eq("busy_s1_state", {124'd0, o_state}, 128'd1);
        check_eq("busy_s1_data", o_data, 128'h00000014_00000013_00000012_00000011);
      end
      if (k == 7) check_eq("busy_idle_ready", {127'd0, o_ready}, 128'd1);
      if (k == 8) begin
        i_valid = 1'b0;
        check_eq("busy_s5_addr0", {122'd0, o_ram_addr}, 128'h14);
      end
      if (k >= 7 && k <= 12) check_eq("busy_no_early_valid", {127'd0, o_valid}, 128'd0);
      if (k == 13) begin
        check_eq("busy_s5_valid", {127'd0, o_valid}, 128'd1);
        check_eq("busy_s5_state", {124'd0, o_state}, 128'd5);
        check_eq("busy_s5_data", o_data, 128'h00000054_00000053_00000052_00000051);
      end
    end

    // Hold: 20 idle cycles, output unchanged and no pulse.
    @(negedge clk);
    held_data  = 128'h00000054_00000053_00000052_00000051;
    held_state = 4'd5;
    bad        = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_valid !== 1'b0 || o_data !== held_data || o_state !== held_state) bad = 1'b1;
    end
    check_eq("hold_stable", {127'd0, bad}, 128'd0);

    // Reset in the second read of state 2.
    request(4'd2);
    @(negedge clk);
    i_valid = 1'b0;
    check_eq("rstmid_rd0", {122'd0, o_ram_addr}, 128'h08);
    @(negedge clk);
    check_eq("rstmid_rd1", {122'd0, o_ram_addr}, 128'h09);
    rst = 1'b1;
    #1;
    check_eq("rstmid_rd_en", {127'd0, o_ram_rd_en}, 128'd0);
    check_eq("rstmid_data",  o_data, 128'd0);
    check_eq("rstmid_state", {124'd0, o_state}, 128'd0);
    check_eq("rstmid_valid", {127'd0, o_valid}, 128'd0);
    check_eq("rstmid_ready", {127'd0, o_ready}, 128'd1);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid !== 1'b0 || o_ram_rd_en !== 1'b0) bad = 1'b1;
    end
    check_eq("rstmid_quiet", {127'd0, bad}, 128'd0);
    fetch_row(4'd7, 128'h00000074_00000073_00000072_00000071, "s7");

    // State 6 with slot 2 overwritten; the row maximum is that slot.
    mem[6*4 + 2] = 32'h7FFF0000;
    fetch_row(4'd6, 128'h00000064_7FFF0000_00000062_00000061, "s6");
    mx = 32'd0;
    for (int a = 0; a < 4; a++)
      if ($signed(o_data[32*a +: 32]) > $signed(mx)) mx = o_data[32*a +: 32];
    check_eq("s6_max", {96'd0, mx}, {96'd0, 32'h7FFF0000});

    // Last state: addresses 0x3C..0x3F, no wrap.
    fetch_row(4'd15, 128'h000000F4_000000F3_000000F2_000000F1, "s15");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_q_row_fetch
`default_nettype wire
